ddfs_phase_gen: RTL and testbench
=================================

# ddfs_phase_gen

Phase accumulator for the DDFS datapath: integrates a frequency control word each enabled cycle and drives the address input of the sine lookup ROM directly. Frequency and phase-offset updates arrive over a valid/ready config port and are applied only at safe sync points (accumulator wrap, idle, or clear), so the output never glitches mid-period. The block also supplies a per-period wrap strobe for downstream framing.

## Interface
- PHASE_WIDTH, 32, accumulator/FCW/offset width
- ADDR_WIDTH, 8, ROM address width; must be ≤ PHASE_WIDTH
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- en  in  1  advance accumulator this cycle
- clear_i  in  1  synchronous phase clear (accumulator to 0)
- fcw_i  in  PHASE_WIDTH  requested frequency control word
- poff_i  in  PHASE_WIDTH  requested phase offset
- cfg_valid  in  1  fcw_i/poff_i valid
- cfg_ready  out  1  config slot free
- addr_o  out  ADDR_WIDTH  ROM address = top ADDR_WIDTH bits of (acc + poff_a)
- phase_o  out  PHASE_WIDTH  raw accumulator value acc
- wrap_o  out  1  one-cycle pulse: accumulator carried out on this update

## Operation
- Registers: acc, fcw_a/poff_a (active), fcw_p/poff_p (pending), pending flag, addr_o, wrap_o.
- Config FSM, two states: IDLE (pending=0) and PEND (pending=1). cfg_ready = pending==0 and rst_n==1.
- IDLE→PEND at edge with cfg_valid && cfg_ready: capture fcw_i/poff_i into fcw_p/poff_p.
- PEND→IDLE at apply edge: first edge after acceptance where clear_i=1, or en=0, or en=1 and the accumulator add carries out. At that edge fcw_a<=fcw_p, poff_a<=poff_p. Acceptance and apply never happen on the same edge.
- Priority per edge: rst_n=0 > clear_i > en > hold.
- clear_i=1: acc<=0; addr_o<=top(poff_x); wrap_o<=0. poff_x = poff_p if applying this edge, else poff_a.
- en=1 (no clear): {carry, sum} = acc + fcw_a (PHASE_WIDTH+1 bits); acc<=sum (mod 2^PHASE_WIDTH); wrap_o<=carry; addr_o<=top(sum + poff_x), offset add modulo 2^PHASE_WIDTH. The increment uses old fcw_a even on an apply edge.
- en=0 (no clear): acc holds; wrap_o<=0; addr_o<=top(acc + poff_x) (refreshes when a new offset applies, otherwise unchanged).
- phase_o is acc.
- fcw_a=0 with en=1: acc frozen, no carry, pending update waits indefinitely. User drops en or pulses clear_i.

## Timing
- Reset (rst_n low at edge): acc=0, fcw_a=poff_a=fcw_p=poff_p=0, pending=0, addr_o=0, phase_o=0, wrap_o=0. cfg_ready=0 while rst_n low, 1 from the first cycle after release.
- Reset mid-PEND discards the pending config.
- Latency en→addr_o: 1 cycle. addr_o and wrap_o are registered and aligned: wrap_o=1 in the same cycle addr_o shows the first post-wrap address.
- Config accept→apply: ≥1 edge. With en=0 it is exactly 1 edge. New fcw_a first affects the increment on the edge after apply.
- wrap_o asserts at most once per enabled cycle and never on a clear edge.
- Downstream ROM adds 1 more cycle: sample appears 2 cycles after the en edge.

## Test plan
- Reset, then cfg fcw=0x01000000 poff=0 with en=0: cfg_ready drops one cycle and returns 1 after the apply edge. Raise en: addr_o=0x01,0x02,… each cycle. After 256 enabled cycles addr_o=0x00 with wrap_o=1 for exactly that cycle. phase_o=0x00000000.
- Running at fcw=0x01000000, send fcw=0x02000000 at addr_o=0x10: cfg_ready=0 until the wrap edge. Increments stay +1 through the wrap, then addr_o steps 0x00→0x02→0x04.
- en=0, acc=0, cfg poff=0x80000000: addr_o=0x80 one edge after acceptance. phase_o unchanged.
- en=1 mid-count, pulse clear_i with poff_a=0x40000000: next cycle phase_o=0, addr_o=0x40, wrap_o=0. A pending config applies on that same edge.
- fcw=0xFFFFFFFF from acc=0: acc=0xFFFFFFFF, wrap_o=0. Each following enabled cycle: acc decrements by 1, wrap_o=1.
- rst_n low while PEND with en=1 and fcw_a=0: all outputs zero, cfg_ready=0 during reset and 1 after. Old pending values never appear in fcw_a.

Source files
------------

// File: rtl/ddfs_phase_gen.sv
// ddfs_phase_gen: phase accumulator for the DDFS datapath.
// It adds the active frequency control word to the accumulator on each enabled
// cycle and drives the sine ROM address, which is the top bits of the phase
// plus the active offset. New FCW/offset pairs arrive on a valid/ready port.
// They are held as a pending pair and applied only at a safe point: a wrap, an
// idle cycle or a clear. This keeps the output free of mid-period glitches.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   en         advance the accumulator this cycle
//   clear_i    synchronous phase clear (accumulator to 0)
//   fcw_i      requested frequency control word
//   poff_i     requested phase offset
//   cfg_valid  fcw_i/poff_i valid
//   cfg_ready  config slot free (combinational: no pending pair, not in reset)
//   addr_o     ROM address = top ADDR_WIDTH bits of (acc + active offset)
//   phase_o    raw accumulator value
//   wrap_o     one-cycle pulse when the accumulator carried out on this update
module ddfs_phase_gen #(
  parameter int unsigned PHASE_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clear_i,
  input  logic [PHASE_WIDTH-1:0] fcw_i,
  input  logic [PHASE_WIDTH-1:0] poff_i,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  output logic [ADDR_WIDTH-1:0]  addr_o,
  output logic [PHASE_WIDTH-1:0] phase_o,
  output logic                   wrap_o
);

  localparam int unsigned ADDR_SHIFT = PHASE_WIDTH - ADDR_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t                 state_q, state_d;

  logic [PHASE_WIDTH-1:0] acc_q, acc_d;
  logic [PHASE_WIDTH-1:0] fcw_a_q, fcw_a_d;
  logic [PHASE_WIDTH-1:0] poff_a_q, poff_a_d;
  logic [PHASE_WIDTH-1:0] fcw_p_q, fcw_p_d;
  logic [PHASE_WIDTH-1:0] poff_p_q, poff_p_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   wrap_q, wrap_d;

  logic [PHASE_WIDTH:0]   sum_ext;
  logic                   carry;
  logic                   accept;
  logic                   apply;
  logic [PHASE_WIDTH-1:0] poff_x;
  logic [PHASE_WIDTH-1:0] phase_base;
  logic [PHASE_WIDTH-1:0] phase_off;

  // The increment always uses the FCW that was active before this edge.
  assign sum_ext = {1'b0, acc_q} + {1'b0, fcw_a_q};
  assign carry   = sum_ext[PHASE_WIDTH];

  assign cfg_ready = (state_q == IDLE) && rst_n;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Config FSM. A pair is accepted only in IDLE and applied only in PEND, so
  // acceptance and apply never fall on the same edge.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    apply   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          accept  = 1'b1;
          state_d = PEND;
        end
      end
      PEND: begin
        if (clear_i || !en || carry) begin
          apply   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next state. The address always tracks the new phase plus the
  // offset that is in force after this edge.
  always_comb begin
    acc_d    = acc_q;
    fcw_a_d  = fcw_a_q;
    poff_a_d = poff_a_q;
    fcw_p_d  = fcw_p_q;
    poff_p_d = poff_p_q;
    wrap_d   = 1'b0;

    poff_x = apply ? poff_p_q : poff_a_q;

    if (clear_i) begin
      acc_d      = '0;
      phase_base = '0;
    end else if (en) begin
      acc_d      = sum_ext[PHASE_WIDTH-1:0];
      wrap_d     = carry;
      phase_base = sum_ext[PHASE_WIDTH-1:0];
    end else begin
      phase_base = acc_q;
    end

    phase_off = phase_base + poff_x;
    addr_d    = ADDR_WIDTH'(phase_off >> ADDR_SHIFT);

    if (apply) begin
      fcw_a_d  = fcw_p_q;
      poff_a_d = poff_p_q;
    end
    if (accept) begin
      fcw_p_d  = fcw_i;
      poff_p_d = poff_i;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      fcw_a_q  <= '0;
      poff_a_q <= '0;
      fcw_p_q  <= '0;
      poff_p_q <= '0;
      addr_q   <= '0;
      wrap_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      fcw_a_q  <= fcw_a_d;
      poff_a_q <= poff_a_d;
      fcw_p_q  <= fcw_p_d;
      poff_p_q <= poff_p_d;
      addr_q   <= addr_d;
      wrap_q   <= wrap_d;
    end
  end

  assign addr_o  = addr_q;
  assign phase_o = acc_q;
  assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_ddfs_phase_gen.sv
// Self-checking bench for ddfs_phase_gen: directed scenarios plus random
// traffic, all compared against a behavioural model of the phase generator.
module tb_ddfs_phase_gen;

  localparam int unsigned PW = 32;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          clear_i;
  logic [PW-1:0] fcw_i;
  logic [PW-1:0] poff_i;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [AW-1:0] addr_o;
  logic [PW-1:0] phase_o;
  logic          wrap_o;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state.
  bit [PW-1:0] m_acc, m_fcw_a, m_poff_a, m_fcw_p, m_poff_p;
  bit          m_pend;
  bit [AW-1:0] m_addr;
  bit          m_wrap;

  ddfs_phase_gen #(.PHASE_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clear_i   (clear_i),
    .fcw_i     (fcw_i),
    .poff_i    (poff_i),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .addr_o    (addr_o),
    .phase_o   (phase_o),
    .wrap_o    (wrap_o)
  );

  always #5 clk = ~clk;

  function automatic bit [AW-1:0] top_bits(input bit [PW-1:0] x);
    return AW'(x / (64'd1 << (PW - AW)));
  endfunction

  // Advance the model by one edge using the inputs presented at that edge,
  // then let the DUT take the same edge and settle.
  task automatic tick();
    bit [PW:0]   s;
    bit          cy, app, acc_ok;
    bit [PW-1:0] px;
    if (!rst_n) begin
      m_acc = 0; m_fcw_a = 0; m_poff_a = 0; m_fcw_p = 0; m_poff_p = 0;
      m_pend = 0; m_addr = 0; m_wrap = 0;
    end else begin
      s      = PW'(m_acc) + PW'(m_fcw_a) + 33'd0;
      s      = {1'b0, m_acc} + {1'b0, m_fcw_a};
      cy     = (s >= (33'd1 << PW));
      app    = m_pend && (clear_i || !en || cy);
      acc_ok = !m_pend && cfg_valid;
      px     = app ? m_poff_p : m_poff_a;
      if (clear_i) begin
        m_acc  = 0;
        m_addr = top_bits(px);
        m_wrap = 0;
      end else if (en) begin
        m_acc  = PW'(s);
        m_wrap = cy;
        m_addr = top_bits(m_acc + px);
      end else begin
        m_wrap = 0;
        m_addr = top_bits(m_acc + px);
      end
      if (app) begin
        m_fcw_a = m_fcw_p; m_poff_a = m_poff_p; m_pend = 0;
      end
      if (acc_ok) begin
        m_fcw_p = fcw_i; m_poff_p = poff_i; m_pend = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; en = 0; clear_i = 0; cfg_valid = 0; fcw_i = '0; poff_i = '0;
    tick(); tick();
    n_vec++; if (addr_o !== 8'h00) begin n_err++; $display("FAIL reset_addr got %h exp 00", addr_o); end
    n_vec++; if (phase_o !== 32'h0) begin n_err++; $display("FAIL reset_phase got %h exp 0", phase_o); end
    n_vec++; if (wrap_o !== 1'b0) begin n_err++; $display("FAIL reset_wrap got %b exp 0", wrap_o); end
    n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_low got %b exp 0", cfg_ready); end
    rst_n = 1;
    #1;
    n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_rel got %b exp 1", cfg_ready); end
    tick();
  endtask

  task automatic test_basic_count();
    logic [AW-1:0] exp;
    fcw_i = 32'h0100_0000; poff_i = 32'h0; cfg_valid = 1;
    tick();
    cfg_valid = 0;
    n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL basic_ready_pend got %b exp 0", cfg_ready); end
    tick();
    n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready_apply got %b exp 1", cfg_ready); end
    en = 1;
    for (int i = 0; i < 256; i++) begin
      tick();
      exp = AW'(i + 1);
      n_vec++; if (addr_o !== exp) begin n_err++; $display("FAIL basic_addr i=%0d got %h exp %h", i, addr_o, exp); end
      n_vec++; if (wrap_o !== (i == 255)) begin n_err++; $display("FAIL basic_wrap i=%0d got %b exp %b", i, wrap_o, i == 255); end
    end
    n_vec++; if (phase_o !== 32'h0) begin n_err++; $display("FAIL basic_phase_wrap got %h exp 0", phase_o); end
  endtask

  task automatic test_fcw_change();
    logic [AW-1:0] exp;
    bit            seen;
    for (int i = 0; i < 16; i++) tick();
    n_vec++; if (addr_o !== 8'h10) begin n_err++; $display("FAIL chg_start got %h exp 10", addr_o); end
    fcw_i = 32'h0200_0000; poff_i = 32'h0; cfg_valid = 1;
    tick();
    cfg_valid = 0;
    exp = 8'h11;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      n_vec++; if (addr_o !== exp) begin n_err++; $display("FAIL chg_addr got %h exp %h", addr_o, exp); end
      n_vec++; if (cfg_ready !== (exp == 8'h00)) begin n_err++; $display("FAIL chg_ready addr=%h got %b exp %b", exp, cfg_ready, exp == 8'h00); end
      if (exp == 8'h00) begin
        seen = 1;
        n_vec++; if (wrap_o !== 1'b1) begin n_err++; $display("FAIL chg_wrap got %b exp 1", wrap_o); end
      end else begin
        tick();
        exp = exp + 8'h01;
      end
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL chg_timeout got nowrap exp wrap"); end
    tick();
    n_vec++; if (addr_o !== 8'h02) begin n_err++; $display("FAIL chg_step1 got %h exp 02", addr_o); end
    tick();
    n_vec++; if (addr_o !== 8'h04) begin n_err++; $display("FAIL chg_step2 got %h exp 04", addr_o); end
  endtask

  task automatic test_poff_idle();
    en = 0; clear_i = 1;
    tick();
    clear_i = 0;
    n_vec++; if (phase_o !== 32'h0) begin n_err++; $display("FAIL poff_clear got %h exp 0", phase_o); end
    fcw_i = 32'h0200_0000; poff_i = 32'h8000_0000; cfg_valid = 1;
    tick();
    cfg_valid = 0;
    n_vec++; if (addr_o !== 8'h00) begin n_err++; $display("FAIL poff_accept got %h exp 00", addr_o); end
    tick();
    n_vec++; if (addr_o !== 8'h80) begin n_err++; $display("FAIL poff_apply got %h exp 80", addr_o); end
    n_vec++; if (phase_o !== 32'h0) begin n_err++; $display("FAIL poff_phase got %h exp 0", phase_o); end
    n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL poff_ready got %b exp 1", cfg_ready); end
  endtask

  task automatic test_clear();
    en = 0; fcw_i = 32'h0200_0000; poff_i = 32'h4000_0000; cfg_valid = 1;
    tick();
    cfg_valid = 0;
    tick();
    en = 1;
    for (int i = 0; i < 5; i++) tick();
    clear_i = 1;
    tick();
    clear_i = 0;
    n_vec++; if (phase_o !== 32'h0) begin n_err++; $display("FAIL clr_phase got %h exp 0", phase_o); end
    n_vec++; if (addr_o !== 8'h40) begin n_err++; $display("FAIL clr_addr got %h exp 40", addr_o); end
    n_vec++; if (wrap_o !== 1'b0) begin n_err++; $display("FAIL clr_wrap got %b exp 0", wrap_o); end
    for (int i = 0; i < 3; i++) tick();
    poff_i = 32'h2000_0000; cfg_valid = 1;
    tick();
    cfg_valid = 0;
    n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL clr_pend got %b exp 0", cfg_ready); end
    clear_i = 1;
    tick();
    clear_i = 0;
    n_vec++; if (addr_o !== 8'h20) begin n_err++; $display("FAIL clr_apply_addr got %h exp 20", addr_o); end
    n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL clr_apply_ready got %b exp 1", cfg_ready); end
  endtask

  task automatic test_neg_fcw();
    logic [PW-1:0] exp;
    en = 0; fcw_i = 32'hFFFF_FFFF; poff_i = 32'h0; cfg_valid = 1;
    tick();
    cfg_valid = 0;
    tick();
    clear_i = 1;
    tick();
    clear_i = 0; en = 1;
    tick();
    n_vec++; if (phase_o !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL neg_first got %h exp ffffffff", phase_o); end
    n_vec++; if (wrap_o !== 1'b0) begin n_err++; $display("FAIL neg_first_wrap got %b exp 0", wrap_o); end
    exp = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = exp - 1;
      n_vec++; if (phase_o !== exp) begin n_err++; $display("FAIL neg_dec got %h exp %h", phase_o, exp); end
      n_vec++; if (wrap_o !== 1'b1) begin n_err++; $display("FAIL neg_wrap got %b exp 1", wrap_o); end
    end
  endtask

  task automatic test_reset_pend();
    en = 0; fcw_i = 32'h0; poff_i = 32'h0; cfg_valid = 1;
    tick();
    cfg_valid = 0;
    tick();
    clear_i = 1;
    tick();
    clear_i = 0; en = 1;
    fcw_i = 32'h1234_5678; poff_i = 32'h1111_1111; cfg_valid = 1;
    tick();
    cfg_valid = 0;
    for (int i = 0; i < 4; i++) tick();
    n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL rp_stuck got %b exp 0", cfg_ready); end
    rst_n = 0;
    tick();
    n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL rp_ready_rst got %b exp 0", cfg_ready); end
    n_vec++; if ({addr_o, phase_o, wrap_o} !== '0) begin n_err++; $display("FAIL rp_zero got %h/%h/%b exp 0", addr_o, phase_o, wrap_o); end
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++; if (phase_o !== 32'h0 || addr_o !== 8'h00) begin n_err++; $display("FAIL rp_nostale got %h/%h exp 0/0", phase_o, addr_o); end
      n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL rp_ready got %b exp 1", cfg_ready); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      clear_i   = ($urandom_range(0, 31) == 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      fcw_i     = ($urandom_range(0, 1) != 0) ? $urandom : ($urandom >> $urandom_range(0, 31));
      poff_i    = $urandom;
      tick();
      n_vec++; if (addr_o !== m_addr) begin n_err++; $display("FAIL rnd_addr cyc=%0d got %h exp %h", i, addr_o, m_addr); end
      n_vec++; if (phase_o !== m_acc) begin n_err++; $display("FAIL rnd_phase cyc=%0d got %h exp %h", i, phase_o, m_acc); end
      n_vec++; if (wrap_o !== m_wrap) begin n_err++; $display("FAIL rnd_wrap cyc=%0d got %b exp %b", i, wrap_o, m_wrap); end
      n_vec++; if (cfg_ready !== !m_pend) begin n_err++; $display("FAIL rnd_ready cyc=%0d got %b exp %b", i, cfg_ready, !m_pend); end
    end
    en = 0; clear_i = 0; cfg_valid = 0;
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_fcw_change();
    test_poff_idle();
    test_clear();
    test_neg_fcw();
    test_reset_pend();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
